// File: rtl/cpu_soc_test_top.sv
// Test top around a small RV32I-subset CPU plus instruction/data memory. Synchronises reset,
// stalls the CPU under retire-trace back-pressure and exports one 70-bit record per commit.

module cpu_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [32];

  // Cleared on reset so a restarted program sees the same architectural state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wen && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
endmodule

module cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stall,
  output logic [31:0] inst_addr,
  input  logic [31:0] Instruction,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] Address,
  output logic [3:0]  Write_strb,
  output logic [31:0] Write_data,
  input  logic        Mem_Req_Ack,
  input  logic [31:0] Read_data,
  output logic        inst_retire_valid,
  output logic [69:0] inst_retired
);
  typedef enum logic [0:0] {StExec, StWait} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        ack_held_q;
  logic [31:0] rdata_held_q;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b;
  logic [31:0] rs1v, rs2v, alu_res, mem_rdata, next_pc;
  logic        is_opimm, is_op, is_load, is_store, is_branch, is_mem;
  logic        taken, commit, resp_ok, issue, rd_en;
  logic        RF_wen;
  logic [4:0]  RF_waddr;
  logic [31:0] RF_wdata, pc_retire;

  assign opcode = Instruction[6:0];
  assign rd     = Instruction[11:7];
  assign f3     = Instruction[14:12];
  assign rs1    = Instruction[19:15];
  assign rs2    = Instruction[24:20];
  assign imm_i  = {{20{Instruction[31]}}, Instruction[31:20]};
  assign imm_s  = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
  assign imm_b  = {{19{Instruction[31]}}, Instruction[31], Instruction[7], Instruction[30:25],
                   Instruction[11:8], 1'b0};

  assign is_opimm  = (opcode == 7'b0010011) && (f3 == 3'b000);
  assign is_op     = (opcode == 7'b0110011) && (f3 == 3'b000);
  assign is_load   = (opcode == 7'b0000011) && (f3 == 3'b010);
  assign is_store  = (opcode == 7'b0100011) && (f3 == 3'b010);
  assign is_branch = (opcode == 7'b1100011) && (f3[2:1] == 2'b00);
  assign is_mem    = is_load | is_store;

  cpu_reg_file reg_file (
    .clk    (clk),
    .rst    (rst),
    .wen    (RF_wen),
    .waddr  (RF_waddr),
    .wdata  (RF_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1v),
    .rdata2 (rs2v)
  );

  assign alu_res   = is_op ? (Instruction[30] ? rs1v - rs2v : rs1v + rs2v) : rs1v + imm_i;
  assign mem_rdata = ack_held_q ? rdata_held_q : Read_data;
  assign rd_en     = (is_opimm | is_op | is_load) && (rd != 5'd0);
  assign taken     = is_branch && ((rs1v == rs2v) ^ f3[0]);
  assign next_pc   = taken ? pc_q + imm_b : pc_q + 32'd4;
  assign resp_ok   = Mem_Req_Ack | ack_held_q;
  assign commit    = (state_q == StExec) ? ~is_mem : resp_ok;
  assign issue     = (state_q == StExec) & is_mem & ~cpu_stall & ~rst;

  assign inst_addr  = pc_q;
  assign MemWrite   = issue & is_store;
  assign MemRead    = issue & is_load;
  assign Address    = rs1v + (is_store ? imm_s : imm_i);
  assign Write_strb = 4'hF;
  assign Write_data = rs2v;

  assign inst_retire_valid = commit & ~cpu_stall & ~rst;
  assign RF_wen    = inst_retire_valid & rd_en;
  assign RF_waddr  = RF_wen ? rd : 5'd0;
  assign RF_wdata  = RF_wen ? (is_load ? mem_rdata : alu_res) : 32'd0;
  assign pc_retire = inst_retire_valid ? pc_q : 32'd0;
  assign inst_retired = {pc_retire, RF_wen, RF_waddr, RF_wdata};

  // A response landing during a stall is parked until the stall lifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StExec;
      pc_q         <= '0;
      ack_held_q   <= 1'b0;
      rdata_held_q <= '0;
    end else if (cpu_stall) begin
      if (state_q == StWait && Mem_Req_Ack) begin
        ack_held_q   <= 1'b1;
        rdata_held_q <= Read_data;
      end
    end else begin
      unique case (state_q)
        StExec: begin
          if (is_mem) state_q <= StWait;
          else        pc_q    <= next_pc;
        end
        StWait: begin
          if (resp_ok) begin
            state_q    <= StExec;
            pc_q       <= pc_q + 32'd4;
            ack_held_q <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

module cpu_wrapper (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stall,
  output logic        inst_retire_valid,
  output logic [69:0] inst_retired,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata
);
  logic [31:0] inst_addr, inst;
  logic        mem_read, mem_ack, mem_hit;
  logic [3:0]  mem_strb;
  logic [31:0] mem_rdata;
  logic [3:0]  idx;
  logic [31:0] dmem [16];

  cpu u_cpu (
    .clk               (clk),
    .rst               (rst),
    .cpu_stall         (cpu_stall),
    .inst_addr         (inst_addr),
    .Instruction       (inst),
    .MemWrite          (mem_write),
    .MemRead           (mem_read),
    .Address           (mem_address),
    .Write_strb        (mem_strb),
    .Write_data        (mem_wdata),
    .Mem_Req_Ack       (mem_ack),
    .Read_data         (mem_rdata),
    .inst_retire_valid (inst_retire_valid),
    .inst_retired      (inst_retired)
  );

  // Benchmark: ALU ops, x0 write, store/load, non-ending stores, a 3-pass loop, end store, spin.
  always_comb begin
    inst = 32'h0000_0063;
    case (inst_addr)
      32'h00: inst = 32'h0050_0093;  // addi x1,x0,5
      32'h04: inst = 32'h0010_8133;  // add  x2,x1,x1
      32'h08: inst = 32'h0070_0013;  // addi x0,x0,7
      32'h0C: inst = 32'h0020_2023;  // sw   x2,0(x0)
      32'h10: inst = 32'h0000_2183;  // lw   x3,0(x0)
      32'h14: inst = 32'h0010_0213;  // addi x4,x0,1
      32'h18: inst = 32'h0040_2623;  // sw   x4,12(x0)
      32'h1C: inst = 32'h0000_2823;  // sw   x0,16(x0)
      32'h20: inst = 32'h0030_0293;  // addi x5,x0,3
      32'h24: inst = 32'h0033_0333;  // add  x6,x6,x3
      32'h28: inst = 32'hFFF2_8293;  // addi x5,x5,-1
      32'h2C: inst = 32'hFE02_9CE3;  // bne  x5,x0,-8
      32'h30: inst = 32'h0000_2623;  // sw   x0,12(x0)
      default: inst = 32'h0000_0063; // beq  x0,x0,0
    endcase
  end

  assign mem_hit = (mem_address[31:6] == 26'd0) && (mem_address[1:0] == 2'b00);
  assign idx     = mem_address[5:2];

  always_ff @(posedge clk) begin
    if (mem_write && mem_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_strb[b]) dmem[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ack   <= mem_write | mem_read;
      mem_rdata <= mem_hit ? dmem[idx] : 32'd0;
    end
  end
endmodule

module cpu_soc_test_top #(
  parameter int unsigned RST_SYNC_STAGES = 2,
  parameter logic [31:0] DONE_ADDR       = 32'hC
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        inst_retired_fifo_full,
  output logic        retire_valid,
  output logic [69:0] retire_record,
  output logic        bench_pass
);
  logic [RST_SYNC_STAGES-1:0] rst_sync;
  logic                       cpu_rst;
  logic                       mem_write;
  logic [31:0]                mem_address, mem_wdata;

  // Assert immediately, release only after RST_SYNC_STAGES clean edges.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) rst_sync <= '1;
    else           rst_sync <= {rst_sync[RST_SYNC_STAGES-2:0], 1'b0};
  end
  assign cpu_rst = rst_sync[RST_SYNC_STAGES-1];

  cpu_wrapper u_cpu_wrapper (
    .clk               (sys_clk),
    .rst               (cpu_rst),
    .cpu_stall         (inst_retired_fifo_full),
    .inst_retire_valid (retire_valid),
    .inst_retired      (retire_record),
    .mem_write         (mem_write),
    .mem_address       (mem_address),
    .mem_wdata         (mem_wdata)
  );

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) bench_pass <= 1'b0;
    else bench_pass <= ~cpu_rst & mem_write & (mem_address == DONE_ADDR) & (mem_wdata == 32'd0);
  end
endmodule

// File: tb/tb_cpu_soc_test_top.sv
// Bench: random back-pressure and mid-run resets; every retire record is checked against an
// instruction-level model of the benchmark program.

module tb_cpu_soc_test_top;
  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic        full;
  logic        retire_valid;
  logic [69:0] retire_record;
  logic        bench_pass;

  cpu_soc_test_top dut (
    .sys_clk                (sys_clk),
    .sys_reset              (sys_reset),
    .inst_retired_fifo_full (full),
    .retire_valid           (retire_valid),
    .retire_record          (retire_record),
    .bench_pass             (bench_pass)
  );

  always #5 sys_clk = ~sys_clk;

  typedef enum int {MAddi, MAdd, MLw, MSw, MBne, MBeq} mop_e;
  typedef struct {
    mop_e op;
    int   rd;
    int   rs1;
    int   rs2;
    int   imm;
  } minst_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [16];
  logic [31:0] m_pc;
  int          m_seg, m_total, m_pass, dut_pass;
  bit          phase1;

  task automatic check(string tag, logic [69:0] got, logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic minst_t prog(logic [31:0] pc);
    case (pc)
      32'h00:  return '{MAddi, 1, 0, 0, 5};
      32'h04:  return '{MAdd,  2, 1, 1, 0};
      32'h08:  return '{MAddi, 0, 0, 0, 7};
      32'h0C:  return '{MSw,   0, 0, 2, 0};
      32'h10:  return '{MLw,   3, 0, 0, 0};
      32'h14:  return '{MAddi, 4, 0, 0, 1};
      32'h18:  return '{MSw,   0, 0, 4, 12};
      32'h1C:  return '{MSw,   0, 0, 0, 16};
      32'h20:  return '{MAddi, 5, 0, 0, 3};
      32'h24:  return '{MAdd,  6, 6, 3, 0};
      32'h28:  return '{MAddi, 5, 5, 0, -1};
      32'h2C:  return '{MBne,  0, 5, 0, -8};
      32'h30:  return '{MSw,   0, 0, 0, 12};
      default: return '{MBeq,  0, 0, 0, 0};
    endcase
  endfunction

  task automatic model_step(output logic [69:0] rec, output bit pass);
    minst_t      i;
    logic [31:0] a, b, val, addr, nxt;
    bit          wr;
    i    = prog(m_pc);
    a    = m_regs[i.rs1];
    b    = m_regs[i.rs2];
    val  = '0;
    wr   = 0;
    pass = 0;
    nxt  = m_pc + 32'd4;
    case (i.op)
      MAddi: begin val = a + 32'(i.imm); wr = 1; end
      MAdd:  begin val = a + b; wr = 1; end
      MLw:   begin addr = a + 32'(i.imm); val = m_mem[addr[5:2]]; wr = 1; end
      MSw:   begin
        addr = a + 32'(i.imm);
        m_mem[addr[5:2]] = b;
        pass = (addr == 32'd12) && (b == 32'd0);
      end
      MBne:  if (a != b) nxt = m_pc + 32'(i.imm);
      MBeq:  if (a == b) nxt = m_pc + 32'(i.imm);
      default: ;
    endcase
    if (wr && i.rd != 0) begin
      m_regs[i.rd] = val;
      rec = {m_pc, 1'b1, 5'(i.rd), val};
    end else begin
      rec = {m_pc, 1'b0, 5'd0, 32'd0};
    end
    m_pc = nxt;
  endtask

  task automatic observe();
    logic [69:0] exp_rec;
    bit          exp_pass;
    exp_pass = 0;
    if (sys_reset) begin
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_pc  = '0;
      m_seg = 0;
      check("reset_valid", retire_valid, 1'b0);
      check("reset_record", retire_record, 70'd0);
      check("reset_pass", bench_pass, 1'b0);
    end else begin
      if (full) check("stall_quiet", retire_valid, 1'b0);
      if (retire_valid) begin
        model_step(exp_rec, exp_pass);
        check("retire_record", retire_record, exp_rec);
        m_seg++;
        m_total++;
        if (exp_pass) m_pass++;
      end
      if (phase1) check("bench_pass_timing", bench_pass, exp_pass);
      if (bench_pass) dut_pass++;
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    observe();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int target;
    sys_reset = 1'b1;
    full      = 1'b0;
    phase1    = 0;
    m_total   = 0;
    m_pass    = 0;
    dut_pass  = 0;
    m_seg     = 0;
    m_pc      = '0;
    for (int r = 0; r < 16; r++) m_mem[r] = '0;

    repeat (10) tick();
    sys_reset = 1'b0;
    tick();
    check("cpu_rst_edge1", dut.cpu_rst, 1'b1);
    tick();
    check("cpu_rst_edge2", dut.cpu_rst, 1'b0);

    // Unstalled run through the whole program, exact bench_pass timing.
    phase1 = 1;
    for (int c = 0; c < 200 && m_seg < 30; c++) tick();
    phase1 = 0;
    check("p1_progress", m_seg >= 30, 1'b1);
    check("p1_pass_seen", dut_pass, 1);

    // Random back-pressure, then a solid 50-cycle stall window.
    for (int c = 0; c < 300; c++) begin
      full = ($urandom_range(0, 2) == 0);
      tick();
    end
    full = 1'b1;
    repeat (50) tick();
    full = 1'b0;

    // Resets landing early in the program, before its end store.
    for (int k = 0; k < 3; k++) begin
      sys_reset = 1'b1;
      #1;
      check("async_clear_valid", retire_valid, 1'b0);
      check("async_clear_record", retire_record, 70'd0);
      check("async_clear_pass", bench_pass, 1'b0);
      repeat (3) tick();
      sys_reset = 1'b0;
      target = int'($urandom_range(1, 12));
      for (int c = 0; c < 100 && m_seg < target; c++) begin
        full = ($urandom_range(0, 3) == 0);
        tick();
      end
      check("reset_target_reached", m_seg >= target, 1'b1);
    end

    for (int c = 0; c < 200; c++) begin
      full = ($urandom_range(0, 2) == 0);
      tick();
    end
    full = 1'b0;
    repeat (40) tick();
    check("pass_count", dut_pass, m_pass);
    check("total_retired", m_total > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
